serial_subtractor: RTL and testbench

- Multi-cycle N-bit subtractor computing diff = a - b - b_in, processing W bits per clock from the LSB upward.
- Complements the combinational ripple-carry adder: trades latency for area in datapaths that do not need a single-cycle difference, e.g. the ALU slow path and the compare unit.
- Valid/ready handshake on both input and output.
- Also produces borrow-out, signed-overflow and zero flags.

---
 rtl/serial_subtractor.sv | 137 +++++++++++++
 tb/tb_serial_subtractor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Multi-cycle N-bit subtractor: diff = a - b - b_in, W bits per clock from the LSB up,
// with valid/ready handshakes and borrow/overflow/zero flags captured at completion.
module serial_subtractor #(
  parameter int N = 32,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         b_out,
  output logic         overflow,
  output logic         zero
);

  localparam int CHUNKS = N / W;
  localparam int CW     = $clog2(CHUNKS + 1);

  generate
    if ((W < 1) || (N % W != 0)) begin : g_bad_width
      $error("serial_subtractor: N must be a positive multiple of W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  nb_q;
  logic [N-1:0]  diff_q;
  logic          carry_q;
  logic [CW-1:0] cnt_q;
  logic          a_sign_q;
  logic          b_sign_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          b_out_q;
  logic          overflow_q;
  logic          zero_q;

  logic [W:0]    chain;
  logic [W-1:0]  sum_w;
  logic [N-1:0]  sum_ext;
  logic [N-1:0]  diff_d;
  logic          carry_d;
  logic          last_chunk;

  // W-bit ripple over the low chunk of a and ~b; carry enters as ~borrow.
  assign chain[0] = carry_q;
  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign sum_w[gi]     = a_q[gi] ^ nb_q[gi] ^ chain[gi];
    assign chain[gi + 1] = (a_q[gi] & nb_q[gi]) | (chain[gi] & (a_q[gi] ^ nb_q[gi]));
  end
  assign carry_d = chain[W];

  always_comb begin
    sum_ext          = '0;
    sum_ext[W-1:0]   = sum_w;
  end

  // New sum bits enter at the top so the LSB chunk ends at bit 0 after N/W shifts.
  assign diff_d     = (diff_q >> W) | (sum_ext << (N - W));
  assign last_chunk = (cnt_q == CW'(CHUNKS - 1));

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign b_out     = b_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      nb_q        <= '0;
      diff_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      a_sign_q    <= 1'b0;
      b_sign_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      b_out_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            nb_q       <= ~b;
            carry_q    <= ~b_in;
            a_sign_q   <= a[N-1];
            b_sign_q   <= b[N-1];
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> W;
          nb_q    <= nb_q >> W;
          diff_q  <= diff_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + 1'b1;
          if (last_chunk) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            b_out_q     <= ~carry_d;
            overflow_q  <= (a_sign_q != b_sign_q) && (diff_d[N-1] != a_sign_q);
            zero_q      <= ~|diff_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: six instances (N=8/W=1,4 and N=32/W=1,4,8,32) checked
// against an integer-arithmetic reference of a - b - b_in, directed steps then a random sweep.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [5:0]  iv, ir, bi, ov, out_rdy, bo, of, zf;
  logic [31:0] a_s [6];
  logic [31:0] b_s [6];
  logic [31:0] d_s [6];

  int nvec = 0;
  int nmis = 0;

  for (genvar gi = 0; gi < 6; gi++) begin : g_dut
    localparam int NN = (gi < 2) ? 8 : 32;
    localparam int WW = (gi == 0) ? 1 : (gi == 1) ? 4 : (gi == 2) ? 1 :
                        (gi == 3) ? 4 : (gi == 4) ? 8 : 32;
    logic [NN-1:0] d_loc;
    serial_subtractor #(.N(NN), .W(WW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[gi]),
      .in_ready  (ir[gi]),
      .a         (a_s[gi][NN-1:0]),
      .b         (b_s[gi][NN-1:0]),
      .b_in      (bi[gi]),
      .out_valid (ov[gi]),
      .out_ready (out_rdy[gi]),
      .diff      (d_loc),
      .b_out     (bo[gi]),
      .overflow  (of[gi]),
      .zero      (zf[gi])
    );
    assign d_s[gi] = 32'(d_loc);
  end

  function automatic int nof(input int k);
    return (k < 2) ? 8 : 32;
  endfunction

  function automatic int wof(input int k);
    case (k)
      0: return 1;
      1: return 4;
      2: return 1;
      3: return 4;
      4: return 8;
      default: return 32;
    endcase
  endfunction

  // Reference: exact integer subtraction, then reduce to n bits and classify.
  function automatic void ref_sub(input int n, input logic [31:0] av, input logic [31:0] bv,
                                  input logic bin, output logic [31:0] d, output logic eb,
                                  output logic eo, output logic ez);
    longint m, ud, sa, sb, sd;
    m  = longint'(1) << n;
    ud = longint'(av) - longint'(bv) - longint'(bin);
    eb = (ud < 0);
    d  = 32'((ud + m) % m);
    sa = longint'(av);
    if (sa >= m / 2) sa -= m;
    sb = longint'(bv);
    if (sb >= m / 2) sb -= m;
    sd = sa - sb - longint'(bin);
    eo = (sd < -(m / 2)) || (sd >= m / 2);
    ez = (d == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input int k, input logic [31:0] av_in, input logic [31:0] bv_in,
                       input logic bin, input int hold, input bit noise);
    int n, w, lat, cnt;
    logic [31:0] av, bv, ed;
    logic eb, eo, ez;
    n  = nof(k);
    w  = wof(k);
    av = (n == 32) ? av_in : (av_in & 32'hFF);
    bv = (n == 32) ? bv_in : (bv_in & 32'hFF);
    ref_sub(n, av, bv, bin, ed, eb, eo, ez);
    cnt = 0;
    while (ir[k] !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("in_ready_idle", 32'(ir[k]), 32'd1);
    a_s[k] = av; b_s[k] = bv; bi[k] = bin; iv[k] = 1'b1;
    out_rdy[k] = (hold == 0);
    @(posedge clk); #1;
    chk("in_ready_run", 32'(ir[k]), 32'd0);
    iv[k] = noise;
    if (noise) begin
      a_s[k] = $urandom; b_s[k] = $urandom; bi[k] = 1'($urandom_range(0, 1));
    end
    lat = 0;
    while (ov[k] !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (noise) begin
        iv[k] = 1'($urandom_range(0, 1)); a_s[k] = $urandom;
      end
    end
    chk("latency", 32'(lat), 32'(n / w));
    chk("diff", d_s[k], ed);
    chk("b_out", 32'(bo[k]), 32'(eb));
    chk("overflow", 32'(of[k]), 32'(eo));
    chk("zero", 32'(zf[k]), 32'(ez));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(ov[k]), 32'd1);
      chk("hold_diff", d_s[k], ed);
      chk("hold_flags", 32'({bo[k], of[k], zf[k]}), 32'({eb, eo, ez}));
      chk("hold_in_ready", 32'(ir[k]), 32'd0);
      if (noise) begin
        iv[k] = ~iv[k]; b_s[k] = $urandom;
      end
    end
    out_rdy[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    chk("out_valid_drop", 32'(ov[k]), 32'd0);
    chk("in_ready_back", 32'(ir[k]), 32'd1);
    out_rdy[k] = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; iv = '0; bi = '0; out_rdy = '0;
    for (int k = 0; k < 6; k++) begin
      a_s[k] = '0; b_s[k] = '0;
    end
    #1;
    chk("rst_in_ready", 32'(ir), 32'd0);
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_flags", 32'({bo, of, zf}), 32'd0);
    chk("rst_diff", d_s[2], 32'd0);
    #20;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 32'(ir), 32'h3F);

    do_op(0, 32'd100, 32'd58, 1'b0, 0, 1'b0);
    do_op(0, 32'h00, 32'h01, 1'b0, 0, 1'b0);
    do_op(0, 32'h80, 32'h01, 1'b0, 0, 1'b0);
    do_op(1, 32'h05, 32'h05, 1'b0, 0, 1'b0);
    do_op(1, 32'h05, 32'h05, 1'b1, 0, 1'b0);
    do_op(0, 32'hC3, 32'h5A, 1'b1, 5, 1'b1);
    do_op(1, 32'h7F, 32'h80, 1'b0, 5, 1'b1);

    // Abort three cycles into RUN with a reset between clock edges.
    do_op(0, 32'h00, 32'hFF, 1'b1, 0, 1'b0);
    a_s[0] = 32'd100; b_s[0] = 32'd58; bi[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrun_valid", 32'(ov[0]), 32'd0);
    #2; rst_n = 1'b0;
    #1;
    chk("async_diff", d_s[0], 32'd0);
    chk("async_valid", 32'(ov[0]), 32'd0);
    chk("async_flags", 32'({bo[0], of[0], zf[0]}), 32'd0);
    chk("async_in_ready", 32'(ir), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rerelease_in_ready", 32'(ir), 32'h3F);
    do_op(0, 32'd7, 32'd3, 1'b0, 0, 1'b0);

    for (int k = 2; k < 6; k++) begin
      for (int i = 0; i < 250; i++) begin
        do_op(k, pick(), pick(), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
              ($urandom_range(0, 3) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
